// File: rtl/data_mem_pipe_pkg.sv
// Shared types and helpers for the pipelined byte-addressed data memory.
// Response records travel through the read pipeline and the response buffer.
package dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_BYTE = 2'd0,
    DMEM_HALF = 2'd1,
    DMEM_WORD = 2'd2,
    DMEM_RSVD = 2'd3
  } dmem_size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        wen;
    logic [1:0]  err;
  } dmem_resp_s;

  localparam int DMEM_ERR_MISALIGN = 0;
  localparam int DMEM_ERR_OOB      = 1;
  localparam int DMEM_RESP_W       = $bits(dmem_resp_s);

  // Narrow reads are returned low-aligned, zero- or sign-extended to 32 bits.
  function automatic logic [31:0] dmem_extend(input logic [31:0] raw,
                                              input dmem_size_e size,
                                              input logic sgn);
    logic [31:0] res;
    res = raw;
    case (size)
      DMEM_BYTE: res = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      DMEM_HALF: res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default:   res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bundle between the core's MEM stage and the data memory.
// Request transfers when req_valid_i && req_ready_o at a clk edge; ready never looks at valid.
// Response transfers when resp_valid_o && resp_yumi_i; yumi may only be raised while valid is high.
interface data_mem_pipe_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_yumi_i;
  logic [31:0] resp_rdata_o;
  logic        resp_wen_o;
  logic [1:0]  resp_err_o;

  modport master (
    output req_valid_i, req_wen_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    output resp_yumi_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_wen_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_wen_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    input  resp_yumi_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_wen_o, resp_err_o
  );
endinterface

// File: rtl/data_mem_pipe_resp_fifo.sv
// In-order response buffer with wrap-bit pointers; head is read straight from storage.
// Outputs are forced to zero while empty so reset clears them asynchronously.
module dmem_resp_fifo #(
  parameter int width_p = 35,
  parameter int els_p   = 4,
  localparam int ptr_w  = $clog2(els_p) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [width_p-1:0] push_data,
  output logic               valid,
  output logic [width_p-1:0] data,
  input  logic               yumi,
  output logic [ptr_w-1:0]   count
);
  localparam int idx_w = ptr_w - 1;

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wptr_q;
  logic [ptr_w-1:0]   rptr_q;
  logic               empty;
  logic               full;
  logic               pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[idx_w] != rptr_q[idx_w]) &&
                 (wptr_q[idx_w-1:0] == rptr_q[idx_w-1:0]);
  assign pop   = yumi && !empty;
  assign valid = !empty;
  assign data  = empty ? '0 : mem_q[rptr_q[idx_w-1:0]];
  assign count = wptr_q - rptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ptr_w'(1);
      if (pop)  rptr_q <= rptr_q + ptr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[idx_w-1:0]] <= push_data;
  end

  // A push into a full buffer is only safe when the head leaves on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(push && full && !pop))
        else $error("dmem_resp_fifo: push while full");
      assert (!(yumi && empty))
        else $error("dmem_resp_fifo: yumi with no response available");
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data RAM with configurable read latency, sized/sign-extended
// accesses and a credit-limited in-order response buffer.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int addr_width_p = 12,
  parameter int latency_p    = 2,
  parameter int fifo_els_p   = 4
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_pipe_if.slave  bus
);
  localparam int cnt_w     = $clog2(fifo_els_p) + 1;
  localparam int mem_bytes = 1 << addr_width_p;

  logic [7:0]              mem_q [mem_bytes];
  logic                    ready_en_q;
  logic                    accept;
  dmem_size_e              size;
  logic                    misalign;
  logic                    oob;
  logic [1:0]              err;
  logic [addr_width_p-1:0] idx;
  logic [31:0]             raw;
  dmem_resp_s              stage_in;
  dmem_resp_s              push_data;
  dmem_resp_s              head;
  logic                    push;
  logic                    fifo_valid;
  logic [DMEM_RESP_W-1:0]  fifo_data;
  logic [cnt_w-1:0]        fifo_cnt;
  int                      inflight;
  int                      outstanding;

  // Ready stays low through the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign outstanding     = inflight + int'(fifo_cnt);
  assign bus.req_ready_o = ready_en_q && (outstanding < fifo_els_p);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign idx             = bus.req_addr_i[addr_width_p-1:0];
  assign raw             = {mem_q[idx + addr_width_p'(3)], mem_q[idx + addr_width_p'(2)],
                            mem_q[idx + addr_width_p'(1)], mem_q[idx]};

  always_comb begin
    size     = dmem_size_e'(bus.req_size_i);
    misalign = 1'b0;
    case (size)
      DMEM_BYTE: misalign = 1'b0;
      DMEM_HALF: misalign = bus.req_addr_i[0];
      DMEM_WORD: misalign = (bus.req_addr_i[1:0] != 2'b00);
      default:   misalign = 1'b1;
    endcase
    oob                    = ((bus.req_addr_i >> addr_width_p) != 32'd0);
    err                    = 2'b00;
    err[DMEM_ERR_MISALIGN] = misalign;
    err[DMEM_ERR_OOB]      = oob;
    stage_in.wen           = bus.req_wen_i;
    stage_in.err           = err;
    stage_in.rdata         = (bus.req_wen_i || (err != 2'b00)) ? 32'd0
                             : dmem_extend(raw, size, bus.req_signed_i);
  end

  // Errored writes never touch storage; error-free sizes are only byte/half/word.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wen_i && (err == 2'b00)) begin
      mem_q[idx] <= bus.req_wdata_i[7:0];
      if (size != DMEM_BYTE) mem_q[idx + addr_width_p'(1)] <= bus.req_wdata_i[15:8];
      if (size == DMEM_WORD) begin
        mem_q[idx + addr_width_p'(2)] <= bus.req_wdata_i[23:16];
        mem_q[idx + addr_width_p'(3)] <= bus.req_wdata_i[31:24];
      end
    end
  end

  // The buffer register itself is the final latency stage.
  generate
    if (latency_p == 1) begin : g_direct
      assign push      = accept;
      assign push_data = stage_in;
      assign inflight  = 0;
    end else begin : g_pipe
      localparam int stages = latency_p - 1;
      logic [stages-1:0] v_q;
      dmem_resp_s        d_q [stages];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_q <= '0;
        end else begin
          v_q[0] <= accept;
          for (int i = 1; i < stages; i++) v_q[i] <= v_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        d_q[0] <= stage_in;
        for (int i = 1; i < stages; i++) d_q[i] <= d_q[i-1];
      end

      always_comb begin
        inflight = 0;
        for (int i = 0; i < stages; i++) inflight += int'(v_q[i]);
      end

      assign push      = v_q[stages-1];
      assign push_data = d_q[stages-1];
    end
  endgenerate

  dmem_resp_fifo #(
    .width_p (DMEM_RESP_W),
    .els_p   (fifo_els_p)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .yumi      (bus.resp_yumi_i),
    .count     (fifo_cnt)
  );

  assign head             = fifo_data;
  assign bus.resp_valid_o = fifo_valid;
  assign bus.resp_rdata_o = head.rdata;
  assign bus.resp_wen_o   = head.wen;
  assign bus.resp_err_o   = head.err;

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised successor of the single-cycle data memory: byte-addressed RAM with configurable read latency, byte/half/word access with optional sign extension, and a response buffer so the core can issue back-to-back requests.
- Sits between the core's MEM stage and backing storage.
- Request side uses valid/ready; response side uses valid/yumi.

Parameters:
addr_width_p, 12, byte-address bits; memory holds 2**addr_width_p bytes
latency_p, 2, cycles from request accept to response entering buffer (>=1)
fifo_els_p, 4, response buffer depth and max outstanding requests (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid&ready
req_wen_i  in  1  1=write, 0=read
req_size_i  in  2  dmem_size_e: 0 byte, 1 half, 2 word, 3 reserved
req_signed_i  in  1  sign-extend byte/half reads
req_addr_i  in  32  byte address
req_wdata_i  in  32  write data, low-aligned
resp_valid_o  out  1  response available
resp_yumi_i  in  1  consumer takes response (legal only when resp_valid_o)
resp_rdata_o  out  32  read data; 0 for writes and errors
resp_wen_o  out  1  echo of request wen
resp_err_o  out  2  bit0 misaligned, bit1 out-of-bounds

Behaviour:
- Reset (async assert, sync release): req_ready_o=0 while asserted, then 1; resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, resp_wen_o=0; pipeline valids and all counters cleared; memory contents not reset. Reset mid-operation drops all in-flight requests and buffered responses.
- Accept: outstanding = in-flight pipeline entries + buffer occupancy. req_ready_o = (outstanding < fifo_els_p). It is combinational from registered state and never depends on req_valid_i. Accept and yumi in the same cycle: outstanding unchanged.
- Error checks at accept:
  - misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - OOB: any addr bit >= addr_width_p set.
- Writes: performed in the accept cycle on the clk edge, only if no error. Write byte lanes: byte writes wdata[7:0], half writes wdata[15:0], word writes wdata[31:0]. Little-endian at addr..addr+n-1.
- Reads: data sampled at the accept edge, so a read sees writes accepted in earlier cycles. Read data then passes through latency_p-1 further register stages. Byte/half results are zero- or sign-extended per req_signed_i; a request with an error returns 0.
- Every accepted request, write included, produces exactly one response, delivered in order; the response is visible latency_p cycles after accept when the buffer is empty.
- Response buffer: FIFO of {rdata, wen, err}, output registered from head. Pop on resp_yumi_i. Push and pop in the same cycle are legal when full or empty-bypass is not required (no bypass: minimum latency is exactly latency_p).
- Yumi with resp_valid_o=0: ignored, $error in simulation.
- Credit scheme guarantees the FIFO never overflows; overflow is an assertion failure.
- Pointer wrap: log2(fifo_els_p)+1-bit pointers; full when MSBs differ and indices are equal.

Decomposition:
- Package dmem_pkg: dmem_size_e enum; dmem_resp_s struct {rdata[31:0], wen, err[1:0]}; constants DMEM_ERR_MISALIGN=0, DMEM_ERR_OOB=1.
- Sub-module dmem_resp_fifo (parametrised by element type width and fifo_els_p; valid/yumi output, push input). Holds the buffer and occupancy count.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 on next cycle → one write response (rdata 0, err 0), then read response 0xDEADBEEF exactly latency_p cycles after the read accept.
- Byte read @0x13 after the above, signed=1 → 0xFFFFFFDE; signed=0 → 0x000000DE. Half read @0x12 signed=1 → 0xFFFFDEAD.
- Word write @0x0000_1002 with addr_width_p=12 → err=2'b11, memory unchanged; word read @0x1000 → rdata 0, err=2'b10.
- Issue 6 back-to-back reads with resp_yumi_i=0 (fifo_els_p=4) → exactly 4 accepted, req_ready_o=0 thereafter. Assert yumi one cycle → ready returns next cycle. Responses arrive in order.
- Continuous traffic, valid and yumi held high → one accept and one response per cycle in steady state, outstanding stable.
- Assert reset with 3 outstanding → resp_valid_o=0 immediately (async). After release, ready=1 and no stale responses; memory retains data written before reset.
